// File: rtl/me_pkg.sv
// ============================================================================
// Module  : me_pkg
// Brief   : Shared types, constants and MV decode for the me266 frame scheduler
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package me_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_KICK    = 3'd1,
    ST_RUN     = 3'd2,
    ST_COLLECT = 3'd3,
    ST_EMIT    = 3'd4
  } state_t;

  localparam int SAD_W    = 14;
  localparam int MV_W     = 4;
  localparam int SAD_BITS = 14;
  localparam int MV_BITS  = 4;
  localparam logic [SAD_W-1:0] SAD_ERR = 14'h3FFF;

  typedef struct packed {
    logic [SAD_W-1:0] sad;
    logic [MV_W:0]    mvx;
    logic [MV_W:0]    mvy;
    logic [5:0]       blk_x;
    logic [5:0]       blk_y;
  } result_t;

  // The core's MV range is -7..+8, so code 1000 means +8 rather than -8.
  function automatic logic [MV_W:0] mv_decode(input logic [MV_W-1:0] code);
    if (code == 4'b1000) return 5'b01000;
    else                 return {code[MV_W-1], code};
  endfunction

endpackage

`default_nettype wire

// File: rtl/me_result_deser.sv
// ============================================================================
// Module  : me_result_deser
// Brief   : Deserialises the core's MSB-first SAD/MV bit stream, flags complete/short
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module me_result_deser
  import me_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_run,
  input  logic             i_collect,
  input  logic             i_strobe,
  input  logic             i_sad_bit,
  input  logic             i_x_bit,
  input  logic             i_y_bit,
  output logic             o_complete,
  output logic             o_short,
  output logic [SAD_W-1:0] o_sad,
  output logic [MV_W-1:0]  o_x_code,
  output logic [MV_W-1:0]  o_y_code
);

  localparam int CNT_W = $clog2(SAD_BITS + 1);

  logic [CNT_W-1:0] r_cnt;
  logic [SAD_W-2:0] r_sad_sr;
  logic [MV_W-1:0]  r_x_sr;
  logic [MV_W-1:0]  r_y_sr;
  logic             w_first;
  logic             w_shift;

  assign w_first    = i_run && i_strobe;
  assign w_shift    = i_collect && i_strobe;
  assign o_complete = w_shift && (r_cnt == CNT_W'(SAD_BITS - 1));
  assign o_short    = i_collect && !i_strobe;
  // Includes the bit on the wire so the FSM can load the word on the last strobe.
  assign o_sad      = {r_sad_sr, i_sad_bit};
  assign o_x_code   = r_x_sr;
  assign o_y_code   = r_y_sr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_sad_sr <= '0;
      r_x_sr   <= '0;
      r_y_sr   <= '0;
    end else if (w_first) begin
      r_cnt    <= CNT_W'(1);
      r_sad_sr <= {{(SAD_W-2){1'b0}}, i_sad_bit};
      r_x_sr   <= {{(MV_W-1){1'b0}}, i_x_bit};
      r_y_sr   <= {{(MV_W-1){1'b0}}, i_y_bit};
    end else if (w_shift) begin
      r_cnt    <= r_cnt + CNT_W'(1);
      r_sad_sr <= o_sad[SAD_W-2:0];
      if (r_cnt < CNT_W'(MV_BITS)) begin
        r_x_sr <= {r_x_sr[MV_W-2:0], i_x_bit};
        r_y_sr <= {r_y_sr[MV_W-2:0], i_y_bit};
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/me_frame_sched.sv
// ============================================================================
// Module  : me_frame_sched
// Brief   : Raster-order frame walker for me266: kicks blocks, forwards reads,
//           emits deserialised results. Option macro: ME_SCHED_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module me_frame_sched
  import me_pkg::*;
#(
  parameter int FRAME_W_BLK = 60,
  parameter int FRAME_H_BLK = 34,
  parameter int CUR_BEATS   = 128,
  parameter int REF_BEATS   = 256,
  parameter int ADDR_W      = 24,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              me_start,
  input  logic              me_cur_read,
  input  logic              me_ref_read,
  input  logic              me_sign_sad,
  input  logic              me_sad_out,
  input  logic              me_x_out,
  input  logic              me_y_out,
  output logic              cur_rd_en,
  output logic [ADDR_W-1:0] cur_addr,
  output logic              ref_rd_en,
  output logic [ADDR_W-1:0] ref_addr,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [13:0]       res_sad,
  output logic [4:0]        res_mvx,
  output logic [4:0]        res_mvy,
  output logic [5:0]        res_blk_x,
  output logic [5:0]        res_blk_y
);

  if (FRAME_W_BLK < 1 || FRAME_W_BLK > 64 || FRAME_H_BLK < 1 || FRAME_H_BLK > 64 ||
      CUR_BEATS < 1 || REF_BEATS < 1 || TIMEOUT_CYC < 2) begin : g_param_chk
    $error("me_frame_sched: parameter out of range");
  end

  localparam logic [5:0] c_LAST_X = 6'(FRAME_W_BLK - 1);
  localparam logic [5:0] c_LAST_Y = 6'(FRAME_H_BLK - 1);

  state_t            r_state;
  result_t           r_res;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
  logic              r_me_start;
  logic              r_res_valid;
  logic [5:0]        r_blk_x;
  logic [5:0]        r_blk_y;
  logic [ADDR_W-1:0] r_cur_addr;
  logic [ADDR_W-1:0] r_ref_addr;

  logic              w_run;
  logic              w_collect;
  logic              w_complete;
  logic              w_short;
  logic              w_timeout;
  logic [SAD_W-1:0]  w_sad;
  logic [MV_W-1:0]   w_x_code;
  logic [MV_W-1:0]   w_y_code;

  assign w_run     = (r_state == ST_RUN);
  assign w_collect = (r_state == ST_COLLECT);

  me_result_deser u_deser (
    .clk        (clk),
    .rst        (rst),
    .i_run      (w_run),
    .i_collect  (w_collect),
    .i_strobe   (me_sign_sad),
    .i_sad_bit  (me_sad_out),
    .i_x_bit    (me_x_out),
    .i_y_bit    (me_y_out),
    .o_complete (w_complete),
    .o_short    (w_short),
    .o_sad      (w_sad),
    .o_x_code   (w_x_code),
    .o_y_code   (w_y_code)
  );

`ifdef ME_SCHED_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC);
  logic [TO_W-1:0] r_to_cnt;

  assign w_timeout = w_run && !me_sign_sad && (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));

  // Held at zero outside RUN, so every entry into RUN starts a fresh count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_to_cnt <= '0;
    else if (!w_run) r_to_cnt <= '0;
    else             r_to_cnt <= r_to_cnt + TO_W'(1);
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_res       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_me_start  <= 1'b0;
      r_res_valid <= 1'b0;
      r_blk_x     <= '0;
      r_blk_y     <= '0;
      r_cur_addr  <= '0;
      r_ref_addr  <= '0;
    end else begin
      r_me_start <= 1'b0;
      r_done     <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state    <= ST_KICK;
            r_me_start <= 1'b1;
            r_busy     <= 1'b1;
            r_err      <= 1'b0;
            r_blk_x    <= '0;
            r_blk_y    <= '0;
            r_cur_addr <= '0;
            r_ref_addr <= '0;
          end
        end
        ST_KICK: r_state <= ST_RUN;
        ST_RUN: begin
          if (me_sign_sad) begin
            r_state <= ST_COLLECT;
          end else if (w_timeout) begin
            r_err       <= 1'b1;
            r_res       <= '{sad: SAD_ERR, mvx: '0, mvy: '0, blk_x: r_blk_x, blk_y: r_blk_y};
            r_res_valid <= 1'b1;
            r_state     <= ST_EMIT;
          end
        end
        ST_COLLECT: begin
          if (w_short) begin
            r_err       <= 1'b1;
            r_res       <= '{sad: SAD_ERR, mvx: '0, mvy: '0, blk_x: r_blk_x, blk_y: r_blk_y};
            r_res_valid <= 1'b1;
            r_state     <= ST_EMIT;
          end else if (w_complete) begin
            r_res       <= '{sad: w_sad, mvx: mv_decode(w_x_code), mvy: mv_decode(w_y_code),
                             blk_x: r_blk_x, blk_y: r_blk_y};
            r_res_valid <= 1'b1;
            r_state     <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (r_res_valid && res_ready) begin
            r_res_valid <= 1'b0;
            if (r_blk_x == c_LAST_X && r_blk_y == c_LAST_Y) begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
            end else begin
              if (r_blk_x == c_LAST_X) begin
                r_blk_x <= '0;
                r_blk_y <= r_blk_y + 6'd1;
              end else begin
                r_blk_x <= r_blk_x + 6'd1;
              end
              r_me_start <= 1'b1;
              r_state    <= ST_KICK;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
      // Never cleared per block: addresses run linearly across the whole frame.
      if (w_run && me_cur_read) r_cur_addr <= r_cur_addr + ADDR_W'(1);
      if (w_run && me_ref_read) r_ref_addr <= r_ref_addr + ADDR_W'(1);
    end
  end

  assign cur_rd_en = w_run && me_cur_read;
  assign ref_rd_en = w_run && me_ref_read;
  assign cur_addr  = r_cur_addr;
  assign ref_addr  = r_ref_addr;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign me_start  = r_me_start;
  assign res_valid = r_res_valid;
  assign res_sad   = r_res.sad;
  assign res_mvx   = r_res.mvx;
  assign res_mvy   = r_res.mvy;
  assign res_blk_x = r_res.blk_x;
  assign res_blk_y = r_res.blk_y;

endmodule

`default_nettype wire

// File: doc/me_frame_sched.md
Name: me_frame_sched

Overview:
- Frame-level controller for the me266 motion-estimation core.
- Walks a frame block by block, raster order.
- Starts the core once per block and serves the core's cur_read/ref_read requests as linear memory read addresses.
- Deserialises the core's bit-serial SAD/MV result into a parallel result word, released downstream under a valid/ready handshake.

Parameters:
- FRAME_W_BLK, 60, blocks per row (4K, 64-px blocks)
- FRAME_H_BLK, 34, block rows per frame
- CUR_BEATS, 128, 32-bit cur words read per block
- REF_BEATS, 256, 64-bit ref words read per block
- ADDR_W, 24, width of cur_addr/ref_addr
- TIMEOUT_CYC, 4096, watchdog limit (optional feature only)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle pulse; begins a frame
- busy  out  1  high from cycle after accepted start until done
- done  out  1  one-cycle pulse after last block's result accepted
- err  out  1  sticky protocol/timeout error, cleared by rst or accepted start
- me_start  out  1  one-cycle pulse starting the core on a block
- me_cur_read  in  1  core requests one cur word
- me_ref_read  in  1  core requests one ref word
- me_sign_sad  in  1  core serial-result strobe
- me_sad_out  in  1  serial SAD bit
- me_x_out  in  1  serial MV-x bit
- me_y_out  in  1  serial MV-y bit
- cur_rd_en  out  1  memory read strobe, cur
- cur_addr  out  ADDR_W  cur word address
- ref_rd_en  out  1  memory read strobe, ref
- ref_addr  out  ADDR_W  ref word address
- res_valid  out  1  result available
- res_ready  in  1  downstream accepts result
- res_sad  out  14  unsigned SAD
- res_mvx  out  5  signed MV x, range -7..+8
- res_mvy  out  5  signed MV y, range -7..+8
- res_blk_x  out  6  block column of result
- res_blk_y  out  6  block row of result

Behaviour:
- Reset (async, rst=1):
  - FSM goes to IDLE.
  - All outputs are 0; all counters and addresses are 0; err is 0.
  - Reset mid-frame abandons the frame with no done pulse.
- FSM states: IDLE, KICK, RUN, COLLECT, EMIT.
- IDLE:
  - start=1 → KICK.
  - Clears err, block counters and both address counters.
  - start while not IDLE is ignored.
- KICK:
  - me_start=1 for exactly one cycle → RUN.
- RUN:
  - cur_rd_en = me_cur_read combinationally; on each such cycle, cur_addr increments at the clock edge.
  - ref_rd_en / ref_addr behave the same way with me_ref_read.
  - Addresses stay linear across the frame: block k starts at cur k*CUR_BEATS and ref k*REF_BEATS.
  - Read requests outside RUN are not forwarded.
  - me_sign_sad=1 → COLLECT; this cycle is bit 0 of the result.
- COLLECT:
  - me_sign_sad must stay high for exactly 14 consecutive cycles, starting with the RUN-exit cycle.
  - sad is shifted in MSB first over the 14 cycles.
  - x and y are shifted in MSB first over the first 4 cycles only.
  - x and y are 4-bit two's complement, except code 4'b1000, which decodes to +8. They are sign-extended to 5 bits.
  - If me_sign_sad drops before bit 14: set err, load res_sad=14'h3FFF and mv=0, → EMIT.
- EMIT:
  - res_valid rises the cycle after the 14th bit.
  - Result fields are held stable while res_valid && !res_ready.
  - Leaving EMIT requires res_valid && res_ready.
  - If not the last block: advance blk_x, wrapping at FRAME_W_BLK-1 to 0 and incrementing blk_y; → KICK (me_start occurs the cycle after acceptance).
  - If the last block (FRAME_W_BLK-1, FRAME_H_BLK-1): pulse done, drop busy, → IDLE.
- Extra me_sign_sad highs outside RUN/COLLECT are ignored.
- Address counters wrap modulo 2^ADDR_W with no flag.

Optional Feature:
- Macro: ME_SCHED_TIMEOUT_EN.
- Defined:
  - A counter runs in RUN and resets on entering RUN.
  - Reaching TIMEOUT_CYC with no me_sign_sad sets err and emits a result with sad=14'h3FFF, mv=0.
  - The frame then continues normally.
- Undefined: no counter; RUN waits indefinitely.

Decomposition:
- Package me_pkg:
  - FSM state enum.
  - Constants SAD_W=14, MV_W=4, SAD_BITS=14, MV_BITS=4, SAD_ERR=14'h3FFF.
  - MV decode function (4-bit code → 5-bit signed, 1000→+8).
  - Result struct {sad, mvx, mvy, blk_x, blk_y}.
- Sub-module me_result_deser:
  - Shift registers and the 14-cycle bit counter.
  - Reports "complete" or "short" to the FSM.

Test Plan:
- 2x1 frame; core model issues 128 cur and 256 ref reads per block:
  - block 1 cur_addr runs 128..255, ref_addr 256..511;
  - done pulses once, after the second result is accepted.
- Serial result sad=14'd1234, x=4'b1110, y=4'b1000 → res_sad=1234, res_mvx=-2, res_mvy=+8; res_valid rises 1 cycle after the 14th bit.
- Hold res_ready=0 for 20 cycles → result fields stable, no me_start; res_ready=1 → me_start the next cycle.
- me_sign_sad high for only 9 cycles → err=1, res_sad=16383, mvx=mvy=0, frame continues.
- Assert rst mid-COLLECT → all outputs 0 in the same cycle; a new start runs a full frame from address 0.
- With ME_SCHED_TIMEOUT_EN and TIMEOUT_CYC=16, core never strobes → err=1 and res_sad=16383 emitted after the 16-cycle RUN timeout.
